vx_lru_victim_ctrl: RTL and testbench



---
 rtl/vx_lru_pkg.sv | 20 ++
 rtl/vx_lru_perf_cnt.sv | 19 +
 rtl/vx_lru_victim_ctrl.sv | 143 ++++++++++++++
 tb/tb_vx_lru_victim_ctrl.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/vx_lru_pkg.sv
// Shared types and constants for the LRU replacement controller.
package vx_lru_pkg;

  localparam int unsigned LineAddrW = 8;
  localparam int unsigned PERF_CNTW = 32;

  typedef enum logic [2:0] {
    StIdle,
    StTouch,
    StEvict,
    StWb,
    StFill
  } lru_state_e;

  typedef struct packed {
    logic                 dirty;
    logic [LineAddrW-1:0] line_addr;
  } lru_entry_t;

endpackage

// File: rtl/vx_lru_perf_cnt.sv
// Saturating performance counter with increment enable.
module vx_lru_perf_cnt
  import vx_lru_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 inc,
  output logic [PERF_CNTW-1:0] count
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + PERF_CNTW'(1);
    end
  end

endmodule

// File: rtl/vx_lru_victim_ctrl.sv
// Drives LRU queue push/pop/touch from lookup results and hands victims to writeback.
// Define LRU_CTRL_PERF_EN to build the hit/miss/evict counters; otherwise they read 0.
module vx_lru_victim_ctrl
  import vx_lru_pkg::*;
#(
  parameter int unsigned LINE_ADDRW = LineAddrW,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned ENTRYW     = LINE_ADDRW + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_hit,
  input  logic                  req_dirty,
  input  logic [LINE_ADDRW-1:0] req_line_addr,
  output logic                  q_push,
  output logic                  q_pop,
  output logic [ENTRYW-1:0]     q_data,
  input  logic [ENTRYW-1:0]     q_head,
  input  logic                  q_full,
  input  logic                  q_empty,
  output logic                  evict_valid,
  input  logic                  evict_ready,
  output logic [LINE_ADDRW-1:0] evict_line_addr,
  output logic                  evict_dirty,
  output logic [PERF_CNTW-1:0]  perf_hits,
  output logic [PERF_CNTW-1:0]  perf_misses,
  output logic [PERF_CNTW-1:0]  perf_evicts
);

  if ((DEPTH < 4) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depth_invalid
  end

  lru_state_e            state_q;
  logic [LINE_ADDRW-1:0] addr_q;
  logic                  dirty_q;

  // A full miss never coincides with an empty queue, so q_empty needs no decoding.
  logic unused_q_empty;
  assign unused_q_empty = q_empty;

  // All outputs are registered alongside the state so no input reaches an output.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= StIdle;
      req_ready       <= 1'b1;
      q_push          <= 1'b0;
      q_pop           <= 1'b0;
      q_data          <= '0;
      evict_valid     <= 1'b0;
      evict_line_addr <= '0;
      evict_dirty     <= 1'b0;
      addr_q          <= '0;
      dirty_q         <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_valid) begin
            addr_q    <= req_line_addr;
            dirty_q   <= req_dirty;
            req_ready <= 1'b0;
            if (req_hit) begin
              state_q <= StTouch;
              q_data  <= {1'b0, req_line_addr};
            end else if (!q_full) begin
              state_q <= StFill;
              q_push  <= 1'b1;
              q_data  <= {req_dirty, req_line_addr};
            end else begin
              state_q <= StEvict;
              q_pop   <= 1'b1;
            end
          end
        end
        StTouch: begin
          state_q   <= StIdle;
          q_data    <= '0;
          req_ready <= 1'b1;
        end
        StEvict: begin
          // q_head is still the LRU entry here since the pop lands on this edge.
          state_q         <= StWb;
          q_pop           <= 1'b0;
          evict_valid     <= 1'b1;
          evict_line_addr <= q_head[LINE_ADDRW-1:0];
          evict_dirty     <= q_head[ENTRYW-1];
        end
        StWb: begin
          if (evict_ready) begin
            state_q     <= StFill;
            evict_valid <= 1'b0;
            q_push      <= 1'b1;
            q_data      <= {dirty_q, addr_q};
          end
        end
        StFill: begin
          state_q   <= StIdle;
          q_push    <= 1'b0;
          q_data    <= '0;
          req_ready <= 1'b1;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

`ifdef LRU_CTRL_PERF_EN
  logic hit_inc, miss_inc, evict_inc;

  assign hit_inc   = (state_q == StIdle) && req_valid && req_hit;
  assign miss_inc  = (state_q == StIdle) && req_valid && !req_hit;
  assign evict_inc = (state_q == StWb) && evict_ready;

  vx_lru_perf_cnt u_hits (
    .clk   (clk),
    .reset (reset),
    .inc   (hit_inc),
    .count (perf_hits)
  );

  vx_lru_perf_cnt u_misses (
    .clk   (clk),
    .reset (reset),
    .inc   (miss_inc),
    .count (perf_misses)
  );

  vx_lru_perf_cnt u_evicts (
    .clk   (clk),
    .reset (reset),
    .inc   (evict_inc),
    .count (perf_evicts)
  );
`else
  assign perf_hits   = '0;
  assign perf_misses = '0;
  assign perf_evicts = '0;
`endif

endmodule

// File: tb/tb_vx_lru_victim_ctrl.sv
// Bench for vx_lru_victim_ctrl: the bench plays the LRU queue and checks each request's trace.
module tb_vx_lru_victim_ctrl;
  import vx_lru_pkg::*;

  localparam int unsigned LINE_ADDRW = 8;
  localparam int unsigned DEPTH      = 4;
  localparam int unsigned ENTRYW     = LINE_ADDRW + 1;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  req_valid, req_ready, req_hit, req_dirty;
  logic [LINE_ADDRW-1:0] req_line_addr;
  logic                  q_push, q_pop, q_full, q_empty;
  logic [ENTRYW-1:0]     q_data, q_head;
  logic                  evict_valid, evict_ready, evict_dirty;
  logic [LINE_ADDRW-1:0] evict_line_addr;
  logic [31:0]           perf_hits, perf_misses, perf_evicts;

  always #5 clk = ~clk;

  vx_lru_victim_ctrl #(
    .LINE_ADDRW (LINE_ADDRW),
    .DEPTH      (DEPTH),
    .ENTRYW     (ENTRYW)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_hit         (req_hit),
    .req_dirty       (req_dirty),
    .req_line_addr   (req_line_addr),
    .q_push          (q_push),
    .q_pop           (q_pop),
    .q_data          (q_data),
    .q_head          (q_head),
    .q_full          (q_full),
    .q_empty         (q_empty),
    .evict_valid     (evict_valid),
    .evict_ready     (evict_ready),
    .evict_line_addr (evict_line_addr),
    .evict_dirty     (evict_dirty),
    .perf_hits       (perf_hits),
    .perf_misses     (perf_misses),
    .perf_evicts     (perf_evicts)
  );

  // Queue contents, index 0 = LRU, last = MRU.
  lru_entry_t  lru[$];
  int unsigned n_hit = 0, n_miss = 0, n_evict = 0;
  int          errors = 0, checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int find(input logic [LINE_ADDRW-1:0] a);
    foreach (lru[i]) if (lru[i].line_addr == a) return i;
    return -1;
  endfunction

  task automatic drive_queue();
    q_full  = (lru.size() == DEPTH);
    q_empty = (lru.size() == 0);
    q_head  = (lru.size() == 0) ? '0 : lru[0];
  endtask

  task automatic chk_perf(input string tag);
`ifdef LRU_CTRL_PERF_EN
    chk({tag, "_hits"}, perf_hits, n_hit);
    chk({tag, "_misses"}, perf_misses, n_miss);
    chk({tag, "_evicts"}, perf_evicts, n_evict);
`else
    chk({tag, "_hits"}, perf_hits, 0);
    chk({tag, "_misses"}, perf_misses, 0);
    chk({tag, "_evicts"}, perf_evicts, 0);
`endif
  endtask

  // One lookup from acceptance back to idle; stall = WB cycles with evict_ready low.
  task automatic request(input logic hit, input logic dirty, input logic [LINE_ADDRW-1:0] addr,
                         input int stall);
    lru_entry_t victim;
    int         idx;
    chk("ready_idle", req_ready, 1);
    req_valid = 1'b1; req_hit = hit; req_dirty = dirty; req_line_addr = addr;
    @(negedge clk);
    req_valid = 1'b0;
    chk("ready_busy", req_ready, 0);
    if (hit) begin
      n_hit++;
      chk("touch_data", q_data, {1'b0, addr});
      chk("touch_push", q_push, 0);
      chk("touch_pop", q_pop, 0);
      idx = find(addr);
      if (idx >= 0) begin
        victim = lru[idx];
        lru.delete(idx);
        lru.push_back(victim);
      end
    end else begin
      n_miss++;
      if (lru.size() == DEPTH) begin
        chk("evict_pop", q_pop, 1);
        chk("evict_push", q_push, 0);
        chk("evict_data", q_data, 0);
        victim = lru.pop_front();
        @(negedge clk);
        drive_queue();
        chk("wb_pop", q_pop, 0);
        for (int i = 0; i <= stall; i++) begin
          chk("wb_valid", evict_valid, 1);
          chk("wb_addr", evict_line_addr, victim.line_addr);
          chk("wb_dirty", evict_dirty, victim.dirty);
          chk("wb_push", q_push, 0);
          evict_ready = (i == stall);
          @(negedge clk);
        end
        evict_ready = 1'b0;
        n_evict++;
        chk("wb_done", evict_valid, 0);
      end
      chk("fill_push", q_push, 1);
      chk("fill_pop", q_pop, 0);
      chk("fill_data", q_data, {dirty, addr});
      lru.push_back('{dirty: dirty, line_addr: addr});
    end
    @(negedge clk);
    drive_queue();
    chk("ready_back", req_ready, 1);
    chk("idle_push", q_push, 0);
    chk("idle_data", q_data, 0);
  endtask

  function automatic logic [LINE_ADDRW-1:0] new_addr();
    logic [LINE_ADDRW-1:0] a = 8'h01;
    for (int t = 0; t < 200; t++) begin
      a = LINE_ADDRW'($urandom_range(1, 255));
      if (find(a) < 0) return a;
    end
    return a;
  endfunction

  initial begin
    logic [LINE_ADDRW-1:0] a;
    reset = 1'b1; req_valid = 1'b0; req_hit = 1'b0; req_dirty = 1'b0; req_line_addr = '0;
    evict_ready = 1'b0;
    drive_queue();
    repeat (2) @(negedge clk);
    chk("rst_ready", req_ready, 1);
    chk("rst_push", q_push, 0);
    chk("rst_pop", q_pop, 0);
    chk("rst_data", q_data, 0);
    chk("rst_evict_valid", evict_valid, 0);
    chk("rst_evict_addr", evict_line_addr, 0);
    chk("rst_evict_dirty", evict_dirty, 0);
    chk_perf("rst");
    reset = 1'b0;
    @(negedge clk);

    // Fill to full, touch 0x22, then a backpressured evict of the now-dirty LRU line 0x11.
    request(1'b0, 1'b0, 8'h11, 0);
    request(1'b0, 1'b0, 8'h22, 0);
    request(1'b0, 1'b0, 8'h33, 0);
    request(1'b0, 1'b0, 8'h44, 0);
    request(1'b1, 1'b0, 8'h22, 0);
    lru[0].dirty = 1'b1;
    drive_queue();
    chk("head_before_evict", q_head, 9'h111);
    request(1'b0, 1'b1, 8'h55, 3);

    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("quiet_data", q_data, 0);
      chk("quiet_push", q_push, 0);
      chk("quiet_pop", q_pop, 0);
    end
    chk_perf("directed");

    for (int n = 0; n < 60; n++) begin
      if (($urandom % 2) == 0) begin
        if ((lru.size() != 0) && (($urandom % 4) != 0))
          a = lru[$urandom_range(0, lru.size() - 1)].line_addr;
        else
          a = LINE_ADDRW'($urandom_range(1, 255));
        request(1'b1, 1'b0, a, 0);
      end else begin
        request(1'b0, 1'($urandom % 2), new_addr(), int'($urandom_range(0, 3)));
      end
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        chk("gap_data", q_data, 0);
        chk("gap_ready", req_ready, 1);
      end
    end
    chk_perf("random");

    // Reset in the middle of a writeback handshake.
    while (lru.size() < DEPTH) request(1'b0, 1'b0, new_addr(), 0);
    req_valid = 1'b1; req_hit = 1'b0; req_dirty = 1'b1; req_line_addr = new_addr();
    @(negedge clk);
    req_valid = 1'b0;
    chk("mid_pop", q_pop, 1);
    @(negedge clk);
    chk("mid_wb_valid", evict_valid, 1);
    #2 reset = 1'b1;
    #1;
    chk("async_evict_valid", evict_valid, 0);
    chk("async_push", q_push, 0);
    chk("async_pop", q_pop, 0);
    @(negedge clk);
    reset = 1'b0;
    n_hit = 0; n_miss = 0; n_evict = 0;
    @(negedge clk);
    chk("post_rst_ready", req_ready, 1);
    chk("post_rst_data", q_data, 0);
    chk("post_rst_evict_valid", evict_valid, 0);
    chk("post_rst_evict_addr", evict_line_addr, 0);
    chk_perf("post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
